// File: rtl/slug_pkg.sv
// rtl/slug_pkg.sv - shared types and constants for the slug motion controller
//
// Purpose: state encoding, move-select codes and datapath widths shared by
// slug_motion and its energy counter.
// Ports: none (package).

package slug_pkg;

  localparam int YW = 11;  // Y position width
  localparam int EW = 8;   // hover energy width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // Select codes for the downstream 4:1 position/sprite mux; 2'b01 is unused.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_UP   = 2'b10;
  localparam logic [1:0] SEL_DOWN = 2'b11;

endpackage

// File: rtl/slug_motion_sat_counter.sv
// rtl/slug_motion_sat_counter.sv - saturating up/down counter used for hover energy
//
// Purpose: W-bit counter that counts up to MAX and down to zero without wrap.
//   Simultaneous inc and dec cancel and the count holds.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous active-high reset, loads INIT
//   inc    in  1  count up by one, saturating at MAX
//   dec    in  1  count down by one, saturating at zero
//   count  out W  current count (registered)

module sat_counter #(
  parameter int           W    = 8,
  parameter logic [W-1:0] MAX  = '1,
  parameter logic [W-1:0] INIT = MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= INIT;
    end else if (inc && !dec) begin
      if (count < MAX) count <= count + ONE;
    end else if (dec && !inc) begin
      if (count != ZERO) count <= count - ONE;
    end
  end

endmodule

// File: rtl/slug_motion.sv
// rtl/slug_motion.sv - per-frame vertical motion controller for the slug sprite
//
// Purpose: IDLE/FLY/DEAD state machine that moves the sprite Y position up
//   (hover, spending energy) or down (fall, recharging energy) once per frame,
//   clamped to [Y_TOP, Y_FLOOR], and freezes on collision.
// Ports:
//   clk       in  1   25 MHz pixel clock
//   reset     in  1   synchronous active-high reset
//   frame     in  1   one-cycle pulse per video frame
//   go        in  1   start play (level)
//   flap      in  1   hover request (level, debounced)
//   collide   in  1   obstacle collision (level)
//   y_pos     out 11  current Y position
//   move_sel  out 2   00 hold, 10 up, 11 down (drives the position mux select)
//   energy    out 8   remaining hover energy
//   dead      out 1   high while in DEAD

module slug_motion
  import slug_pkg::*;
#(
  parameter logic [YW-1:0] Y_START = 11'd300,
  parameter logic [YW-1:0] Y_TOP   = 11'd8,
  parameter logic [YW-1:0] Y_FLOOR = 11'd440,
  parameter logic [YW-1:0] STEP    = 11'd2,
  parameter logic [EW-1:0] E_MAX   = 8'd192
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame,
  input  logic          go,
  input  logic          flap,
  input  logic          collide,
  output logic [YW-1:0] y_pos,
  output logic [1:0]    move_sel,
  output logic [EW-1:0] energy,
  output logic          dead
);

  state_t state;

  // One extra bit so an up move below zero shows as a set MSB instead of
  // wrapping to a large position, and a down move past 2047 cannot wrap.
  logic [YW:0] y_ext;
  logic [YW:0] up_raw;
  logic [YW:0] down_raw;
  logic        up_clamp;
  logic        down_clamp;
  logic        hover;
  logic        move_now;

  assign y_ext      = {1'b0, y_pos};
  assign up_raw     = y_ext - {1'b0, STEP};
  assign down_raw   = y_ext + {1'b0, STEP};
  assign up_clamp   = up_raw[YW] || (up_raw[YW-1:0] < Y_TOP);
  assign down_clamp = down_raw > {1'b0, Y_FLOOR};

  // Hover only while there is energy left; an empty budget turns a held flap
  // into an ordinary fall, which also recharges.
  assign hover    = flap && (energy != '0);
  // Collision wins over a coincident frame: no move and no energy change.
  assign move_now = (state == FLY) && frame && !collide;

  sat_counter #(
    .W    (EW),
    .MAX  (E_MAX),
    .INIT (E_MAX)
  ) u_energy (
    .clk   (clk),
    .reset (reset),
    .inc   (move_now && !hover),
    .dec   (move_now && hover),
    .count (energy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      y_pos    <= Y_START;
      move_sel <= SEL_HOLD;
      dead     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          move_sel <= SEL_HOLD;
          if (go) state <= FLY;
        end
        FLY: begin
          if (collide) begin
            state    <= DEAD;
            dead     <= 1'b1;
            move_sel <= SEL_HOLD;
          end else if (frame) begin
            if (hover) begin
              y_pos    <= up_clamp ? Y_TOP : up_raw[YW-1:0];
              move_sel <= up_clamp ? SEL_HOLD : SEL_UP;
            end else begin
              y_pos    <= down_clamp ? Y_FLOOR : down_raw[YW-1:0];
              move_sel <= down_clamp ? SEL_HOLD : SEL_DOWN;
            end
          end
        end
        DEAD: begin
          move_sel <= SEL_HOLD;
          dead     <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          move_sel <= SEL_HOLD;
          dead     <= 1'b0;
        end
      endcase
    end
  end

endmodule
